// File: rtl/io_input_queue.sv
// Button/switch input queue for the CPU load path: sync, debounce, tagged FIFO, IORead-mapped data/status.
// Optional macro INQ_DEBOUNCE_EN enables per-button debounce counters; otherwise the synced level is used directly.
module io_input_queue #(
   parameter int unsigned DEPTH           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter logic [31:0] DATA_ADDR       = 32'hFFFF_FC80,
   parameter logic [31:0] STAT_ADDR       = 32'hFFFF_FC84
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  sw_in,
   input  logic        btn_a,
   input  logic        btn_b,
   input  logic        io_read,
   input  logic [31:0] addr,
   output logic [31:0] rd_data,
   output logic        irq_pending,
   output logic        overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
      $error("io_input_queue: unsupported DEPTH or DEBOUNCE_CYCLES");
   end

   logic [7:0]       sw_s1_q, sw_s2_q;
   logic [1:0]       btn_s1_q, btn_s2_q;
   logic [1:0]       lvl;
   logic [1:0]       lvl_prev_q;
   logic [1:0]       ev;
   logic             pend_q, pend_d;
   logic [7:0]       pend_sw_q, pend_sw_d;
   logic [8:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             irq_q;
   logic             push, drop, wr_en, pop, full, empty, ovf_set;
   logic [8:0]       push_data;
   logic             data_sel, stat_sel;

   // Two-flop synchronisers; bit 1 is button A, bit 0 is button B
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         btn_s1_q <= '0;
         btn_s2_q <= '0;
      end else begin
         sw_s1_q  <= sw_in;
         sw_s2_q  <= sw_s1_q;
         btn_s1_q <= {btn_a, btn_b};
         btn_s2_q <= btn_s1_q;
      end
   end

`ifdef INQ_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   for (genvar i = 0; i < 2; i++) begin : g_db
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            lvl_q, lvl_d;

      // Level flips only after the synced input has disagreed for DEBOUNCE_CYCLES samples in a row
      always_comb begin
         cnt_d = '0;
         lvl_d = lvl_q;
         if (btn_s2_q[i] != lvl_q) begin
            if (cnt_q == DB_LAST) begin
               lvl_d = btn_s2_q[i];
            end else begin
               cnt_d = cnt_q + DB_W'(1);
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
         end
      end

      assign lvl[i] = lvl_q;
   end
`else
   assign lvl = btn_s2_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_prev_q <= '0;
      end else begin
         lvl_prev_q <= lvl;
      end
   end

   assign ev = lvl & ~lvl_prev_q;

   // One FIFO write per edge: A wins, a parked B goes next, a fresh B is parked behind A
   always_comb begin
      push      = 1'b0;
      push_data = '0;
      drop      = 1'b0;
      pend_d    = pend_q;
      pend_sw_d = pend_sw_q;
      if (ev[1]) begin
         push      = 1'b1;
         push_data = {1'b1, sw_s2_q};
         if (ev[0]) begin
            if (pend_q) begin
               drop = 1'b1;
            end else begin
               pend_d    = 1'b1;
               pend_sw_d = sw_s2_q;
            end
         end
      end else if (pend_q) begin
         push      = 1'b1;
         push_data = {1'b0, pend_sw_q};
         pend_d    = ev[0];
         if (ev[0]) begin
            pend_sw_d = sw_s2_q;
         end
      end else if (ev[0]) begin
         push      = 1'b1;
         push_data = {1'b0, sw_s2_q};
      end
   end

   assign data_sel = io_read && (addr == DATA_ADDR);
   assign stat_sel = io_read && (addr == STAT_ADDR);
   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign pop      = data_sel && !empty;
   assign wr_en    = push && (!full || pop);
   assign ovf_set  = drop || (push && full && !pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      // A fresh overflow on the status-read edge must survive the clear
      if (ovf_set) begin
         overflow_d = 1'b1;
      end else if (stat_sel) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q     <= 1'b0;
         pend_sw_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         pend_sw_q  <= pend_sw_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         irq_q      <= (count_d != '0);
      end
   end

   // Storage needs no reset; entries are only observable while count says they are valid
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_comb begin
      rd_data = '0;
      if (data_sel && !empty) begin
         rd_data = {1'b1, 22'b0, mem_q[rd_ptr_q]};
      end else if (stat_sel) begin
         rd_data = {23'b0, overflow_q, 3'b0, 5'(count_q)};
      end
   end

   assign irq_pending = irq_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_io_input_queue.sv
// Bench for io_input_queue: directed scenarios plus randomized press/read traffic against a FIFO-level model.
`timescale 1ns/1ps
module tb_io_input_queue;

   localparam int          DEPTH  = 4;
   localparam int          DBC    = 4;
   localparam logic [31:0] DATA_A = 32'hFFFF_FC80;
   localparam logic [31:0] STAT_A = 32'hFFFF_FC84;
`ifdef INQ_DEBOUNCE_EN
   localparam int LAT = DBC + 2;
`else
   localparam int LAT = 2;
`endif
   localparam int HOLD = LAT + 3;

   logic        clk;
   logic        rst_n;
   logic [7:0]  sw_in;
   logic        btn_a;
   logic        btn_b;
   logic        io_read;
   logic [31:0] addr;
   logic [31:0] rd_data;
   logic        irq_pending;
   logic        overflow;

   io_input_queue #(
      .DEPTH          (DEPTH),
      .DEBOUNCE_CYCLES(DBC),
      .DATA_ADDR      (DATA_A),
      .STAT_ADDR      (STAT_A)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_in      (sw_in),
      .btn_a      (btn_a),
      .btn_b      (btn_b),
      .io_read    (io_read),
      .addr       (addr),
      .rd_data    (rd_data),
      .irq_pending(irq_pending),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // Reference: an ordered list of accepted entries and a sticky drop flag
   logic [8:0] mq[$];
   bit         movf;

   function automatic void m_push(input bit tag, input logic [7:0] v);
      if (mq.size() < DEPTH) mq.push_back({tag, v});
      else movf = 1'b1;
   endfunction

   function automatic logic [31:0] m_data_read();
      logic [31:0] r;
      r = 32'h0;
      if (mq.size() != 0) r = {1'b1, 22'b0, mq.pop_front()};
      return r;
   endfunction

   function automatic logic [31:0] m_stat_read();
      logic [31:0] r;
      r = {23'b0, movf, 3'b0, 5'(mq.size())};
      movf = 1'b0;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %08h expected %08h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      io_read = 1'b1;
      addr    = a;
      @(negedge clk);
      d = rd_data;
      tick(1);
      io_read = 1'b0;
      addr    = 32'h0;
   endtask

   task automatic read_data(input string tag);
      logic [31:0] d, e;
      e = m_data_read();
      bus_read(DATA_A, d);
      check(tag, d, e);
   endtask

   task automatic read_stat(input string tag);
      logic [31:0] d, e;
      e = m_stat_read();
      bus_read(STAT_A, d);
      check(tag, d, e);
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_irq"}, 32'(irq_pending), 32'(mq.size() != 0));
      check({tag, "_ovf"}, 32'(overflow), 32'(movf));
   endtask

   task automatic press(input bit a, input bit b, input logic [7:0] v);
      sw_in = v;
      btn_a = a;
      btn_b = b;
      tick(HOLD);
      btn_a = 1'b0;
      btn_b = 1'b0;
      tick(HOLD);
      if (a) m_push(1'b1, v);
      if (b) m_push(1'b0, v);
   endtask

   initial begin
      logic [31:0] d, e;
      int          op;
      logic [7:0]  v;
      n_checks = 0;
      n_fail   = 0;
      movf     = 1'b0;
      rst_n    = 1'b1;
      sw_in    = 8'h0;
      btn_a    = 1'b0;
      btn_b    = 1'b0;
      io_read  = 1'b0;
      addr     = 32'h0;
      #1 rst_n = 1'b0;
      tick(3);
      check("rst_irq", 32'(irq_pending), 32'h0);
      check("rst_ovf", 32'(overflow), 32'h0);
      check("rst_idle_rd", rd_data, 32'h0);
      #3 rst_n = 1'b1;
      tick(2);

      read_stat("init_stat");
      read_data("init_data_empty");
      bus_read(DATA_A + 32'd8, d);
      check("unsel_addr", d, 32'h0);
      addr = STAT_A;
      #1;
      check("no_ioread", rd_data, 32'h0);
      addr = 32'h0;

      // Single press: irq rises LAT edges after the first sample
      sw_in = 8'h5A;
      btn_a = 1'b1;
      tick(LAT);
      check("single_irq_early", 32'(irq_pending), 32'h0);
      tick(1);
      check("single_irq_rise", 32'(irq_pending), 32'h1);
      tick(10 - LAT - 1);
      btn_a = 1'b0;
      tick(HOLD);
      m_push(1'b1, 8'h5A);
      bus_read(DATA_A, d);
      check("single_data", d, 32'h8000_015A);
      e = m_data_read();
      read_data("single_empty");
      check_flags("single");

      // Short pulses: filtered with debounce, two B pushes without it
      sw_in = 8'h3C;
      btn_b = 1'b1;
      tick(3);
      btn_b = 1'b0;
      tick(1);
      btn_b = 1'b1;
      tick(3);
      btn_b = 1'b0;
      tick(HOLD);
`ifndef INQ_DEBOUNCE_EN
      m_push(1'b0, 8'h3C);
      m_push(1'b0, 8'h3C);
`endif
      read_stat("glitch_stat");
      read_data("glitch_d0");
      read_data("glitch_d1");
      read_data("glitch_d2");

      // Simultaneous A and B
      press(1'b1, 1'b1, 8'h11);
      read_stat("simul_stat2");
      read_data("simul_a");
      read_stat("simul_stat1");
      read_data("simul_b");
      read_stat("simul_stat0");

      // Overflow on a full FIFO
      for (int i = 1; i <= 5; i++) press(1'b0, 1'b1, 8'(i));
      check_flags("ovf_set");
      read_stat("ovf_stat_first");
      read_stat("ovf_stat_second");
      check_flags("ovf_clr");
      for (int i = 0; i < 5; i++) read_data("ovf_drain");

      // Pop and push landing on the same edge of a full FIFO
      for (int i = 1; i <= 4; i++) press(1'b0, 1'b1, 8'(8'h20 + i));
      sw_in = 8'hA7;
      btn_a = 1'b1;
      tick(LAT);
      e = m_data_read();
      bus_read(DATA_A, d);
      check("pp_pop", d, e);
      m_push(1'b1, 8'hA7);
      tick(HOLD - LAT - 1);
      btn_a = 1'b0;
      tick(HOLD);
      check_flags("pp");
      read_stat("pp_stat");
      for (int i = 0; i < 5; i++) read_data("pp_drain");

      // Asynchronous reset with entries queued and a button held through it
      for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 8'($urandom));
      read_stat("rstm_before");
      sw_in = 8'h6E;
      btn_a = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rstm_irq", 32'(irq_pending), 32'h0);
      check("rstm_ovf", 32'(overflow), 32'h0);
      io_read = 1'b1;
      addr    = STAT_A;
      #1;
      check("rstm_stat", rd_data, 32'h0);
      addr = DATA_A;
      #1;
      check("rstm_data", rd_data, 32'h0);
      io_read = 1'b0;
      addr    = 32'h0;
      mq.delete();
      movf = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick(HOLD + 2);
      btn_a = 1'b0;
      tick(HOLD);
      m_push(1'b1, 8'h6E);
      read_stat("rstm_after_stat");
      read_data("rstm_after_d0");
      read_data("rstm_after_d1");

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         op = int'($urandom_range(0, 5));
         v  = 8'($urandom);
         case (op)
            0:       press(1'b1, 1'b0, v);
            1:       press(1'b0, 1'b1, v);
            2:       press(1'b1, 1'b1, v);
            3, 4:    read_data("rnd_data");
            default: read_stat("rnd_stat");
         endcase
         check_flags("rnd");
      end
      read_stat("final_stat");
      for (int i = 0; i < DEPTH + 1; i++) read_data("final_drain");
      check_flags("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
